pipe_latch_elastic: RTL

Parametrised elastic pipeline latch for the MIPS-DLX pipeline. It carries multi-channel data, a control bundle and a PC between any two stages. Beyond the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches, it adds a valid/ready handshake, flush-to-bubble, halt capture with a sticky halted state, and a transfer counter for the debug unit.

---
 rtl/pipe_latch_elastic_if.sv | 40 ++++
 rtl/pipe_latch_elastic.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_elastic_if.sv
// Handshake and payload bundle between two pipeline stages around pipe_latch_elastic.
// slave: the latch's view; master: the environment that drives beats and consumes output.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

interface pipe_latch_elastic_if #(
   parameter int NB_DATA = 32,
   parameter int N_CH    = 3,
   parameter int NB_CTRL = 16,
   parameter int NB_PC   = `ADDRWIDTH,
   parameter int NB_CNT  = 16
);
   logic                    i_enable_pipe;
   logic                    i_flush;
   logic                    i_valid;
   logic                    o_ready;
   logic [N_CH*NB_DATA-1:0] i_data;
   logic [NB_CTRL-1:0]      i_ctrl;
   logic [NB_PC-1:0]        i_pc;
   logic                    i_halt;
   logic                    o_valid;
   logic                    i_ready;
   logic [N_CH*NB_DATA-1:0] o_data;
   logic [NB_CTRL-1:0]      o_ctrl;
   logic [NB_PC-1:0]        o_pc;
   logic                    o_halt;
   logic                    o_halted;
   logic [NB_CNT-1:0]       o_xfer_cnt;

   modport slave (
      input  i_enable_pipe, i_flush, i_valid, i_data, i_ctrl, i_pc, i_halt, i_ready,
      output o_ready, o_valid, o_data, o_ctrl, o_pc, o_halt, o_halted, o_xfer_cnt
   );

   modport master (
      output i_enable_pipe, i_flush, i_valid, i_data, i_ctrl, i_pc, i_halt, i_ready,
      input  o_ready, o_valid, o_data, o_ctrl, o_pc, o_halt, o_halted, o_xfer_cnt
   );
endinterface

// File: rtl/pipe_latch_elastic.sv
// Elastic pipeline latch: valid/ready handshake, flush-to-bubble, sticky halt capture and a
// saturating transfer counter. Define PIPE_LATCH_SKID_EN for a one-entry skid register with a
// registered o_ready (no combinational path from i_ready).
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

module pipe_latch_elastic #(
   parameter int NB_DATA = 32,
   parameter int N_CH    = 3,
   parameter int NB_CTRL = 16,
   parameter int NB_PC   = `ADDRWIDTH,
   parameter int NB_CNT  = 16
) (
   input logic                i_clock,
   input logic                i_reset,
   pipe_latch_elastic_if.slave io_bus
);
   localparam int NB_BUS = N_CH * NB_DATA;

   logic                r_valid, r_halt, r_halt_pend, r_halted;
   logic [NB_BUS-1:0]   r_data;
   logic [NB_CTRL-1:0]  r_ctrl;
   logic [NB_PC-1:0]    r_pc;
   logic [NB_CNT-1:0]   r_cnt;

   logic                w_valid, w_halt, w_halt_pend, w_halted;
   logic [NB_BUS-1:0]   w_data;
   logic [NB_CTRL-1:0]  w_ctrl;
   logic [NB_PC-1:0]    w_pc;
   logic [NB_CNT-1:0]   w_cnt;

   logic                w_ready, w_accept, w_emit;

   assign w_emit   = r_valid & io_bus.i_ready & io_bus.i_enable_pipe;
   assign w_accept = io_bus.i_valid & w_ready & io_bus.i_enable_pipe;

`ifdef PIPE_LATCH_SKID_EN
   logic                r_skid_valid, r_skid_halt, r_ready;
   logic [NB_BUS-1:0]   r_skid_data;
   logic [NB_CTRL-1:0]  r_skid_ctrl;
   logic [NB_PC-1:0]    r_skid_pc;
   logic                w_skid_valid, w_skid_halt, w_ready_nxt;
   logic [NB_BUS-1:0]   w_skid_data;
   logic [NB_CTRL-1:0]  w_skid_ctrl;
   logic [NB_PC-1:0]    w_skid_pc;

   assign w_ready     = r_ready;
   // Ready is precomputed from next state so it can be registered.
   assign w_ready_nxt = ~w_skid_valid & io_bus.i_enable_pipe & ~w_halt_pend & ~w_halted;
`else
   assign w_ready = io_bus.i_enable_pipe & ~r_halt_pend & ~r_halted & (~r_valid | io_bus.i_ready);
`endif

   // Next-state: flush beats accept/emit; otherwise load, park in skid, drain or bubble.
   always_comb begin
      w_valid     = r_valid;
      w_data      = r_data;
      w_ctrl      = r_ctrl;
      w_pc        = r_pc;
      w_halt      = r_halt;
      w_halt_pend = r_halt_pend;
      w_halted    = r_halted;
      w_cnt       = r_cnt;
`ifdef PIPE_LATCH_SKID_EN
      w_skid_valid = r_skid_valid;
      w_skid_data  = r_skid_data;
      w_skid_ctrl  = r_skid_ctrl;
      w_skid_pc    = r_skid_pc;
      w_skid_halt  = r_skid_halt;
`endif
      if (io_bus.i_flush) begin
         w_valid     = 1'b0;
         w_ctrl      = '0;
         w_halt      = 1'b0;
         w_halt_pend = 1'b0;
`ifdef PIPE_LATCH_SKID_EN
         w_skid_valid = 1'b0;
`endif
      end else begin
         if (w_emit && (r_cnt != {NB_CNT{1'b1}})) w_cnt = r_cnt + NB_CNT'(1);
         if (w_emit && r_halt) begin
            w_halted    = 1'b1;
            w_halt_pend = 1'b0;
         end
         if (w_accept && io_bus.i_halt) w_halt_pend = 1'b1;
`ifdef PIPE_LATCH_SKID_EN
         if (r_skid_valid) begin
            if (w_emit) begin
               w_data       = r_skid_data;
               w_ctrl       = r_skid_ctrl;
               w_pc         = r_skid_pc;
               w_halt       = r_skid_halt;
               w_skid_valid = 1'b0;
            end
         end else if (w_accept) begin
            if (!r_valid || w_emit) begin
               w_valid = 1'b1;
               w_data  = io_bus.i_data;
               w_ctrl  = io_bus.i_ctrl;
               w_pc    = io_bus.i_pc;
               w_halt  = io_bus.i_halt;
            end else begin
               w_skid_valid = 1'b1;
               w_skid_data  = io_bus.i_data;
               w_skid_ctrl  = io_bus.i_ctrl;
               w_skid_pc    = io_bus.i_pc;
               w_skid_halt  = io_bus.i_halt;
            end
         end else if (w_emit) begin
            w_valid = 1'b0;
            w_ctrl  = '0;
            w_halt  = 1'b0;
         end
`else
         if (w_accept) begin
            w_valid = 1'b1;
            w_data  = io_bus.i_data;
            w_ctrl  = io_bus.i_ctrl;
            w_pc    = io_bus.i_pc;
            w_halt  = io_bus.i_halt;
         end else if (w_emit) begin
            w_valid = 1'b0;
            w_ctrl  = '0;
            w_halt  = 1'b0;
         end
`endif
      end
   end

   // Stage registers; everything clears on asynchronous reset.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_ctrl      <= '0;
         r_pc        <= '0;
         r_halt      <= 1'b0;
         r_halt_pend <= 1'b0;
         r_halted    <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_valid     <= w_valid;
         r_data      <= w_data;
         r_ctrl      <= w_ctrl;
         r_pc        <= w_pc;
         r_halt      <= w_halt;
         r_halt_pend <= w_halt_pend;
         r_halted    <= w_halted;
         r_cnt       <= w_cnt;
      end
   end

`ifdef PIPE_LATCH_SKID_EN
   // Skid entry and registered ready.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_ctrl  <= '0;
         r_skid_pc    <= '0;
         r_skid_halt  <= 1'b0;
         r_ready      <= 1'b0;
      end else begin
         r_skid_valid <= w_skid_valid;
         r_skid_data  <= w_skid_data;
         r_skid_ctrl  <= w_skid_ctrl;
         r_skid_pc    <= w_skid_pc;
         r_skid_halt  <= w_skid_halt;
         r_ready      <= w_ready_nxt;
      end
   end
`endif

   assign io_bus.o_ready    = w_ready;
   assign io_bus.o_valid    = r_valid;
   assign io_bus.o_data     = r_data;
   assign io_bus.o_ctrl     = r_ctrl;
   assign io_bus.o_pc       = r_pc;
   assign io_bus.o_halt     = r_halt;
   assign io_bus.o_halted   = r_halted;
   assign io_bus.o_xfer_cnt = r_cnt;
endmodule
